// File: rtl/rv32i_seq_pkg.sv
// rtl/rv32i_seq_pkg.sv - state encoding, opcodes and trap causes for the RV32I multi-cycle sequencer
package rv32i_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_ALU)    || (op == OP_ALUI) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) || (op == OP_JALR) ||
           (op == OP_JAL)    || (op == OP_LUI)  || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter shared by instruction fetch and data access
module mem_wait_timer #(
  parameter int LIMIT = 16,
  parameter int W     = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count unacknowledged request cycles; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/rv32i_mc_sequencer.sv
// rtl/rv32i_mc_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with halt, traps and instret
module rv32i_mc_sequencer
  import rv32i_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  input  logic        resume,
  input  logic [6:0]  op_code,
  input  logic        dec_wr_reg,
  input  logic        dec_mem_wr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        alu_out_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        halted,
  output logic [2:0]  state
);

  state_e state_q;
  logic   waiting;
  logic   tmo_expired;
  logic   tmo_clr;
  logic   tmo_en;
  state_e boundary_next;

  // A request is outstanding while in FETCH/MEM without the matching ack.
  assign waiting = ((state_q == S_FETCH) && !imem_ack) ||
                   ((state_q == S_MEM)   && !dmem_ack);
  // Counter holds at zero outside a wait and restarts on every state change.
  assign tmo_en  = waiting && !tmo_expired;
  assign tmo_clr = !waiting || tmo_expired;

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TMO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  assign boundary_next = halt_req ? S_HALT : S_FETCH;
  assign state         = state_q;
  assign trap          = (state_q == S_TRAP);
  assign halted        = (state_q == S_HALT);

  // Strobes and requests decoded from the current state; only ir_we, mdr_we and the MEM pc_we look at acks.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    alu_out_we = 1'b0;
    mdr_we     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_EXEC: begin
        alu_out_we = 1'b1;
        pc_we      = (op_code == OP_BRANCH);
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_wr;
        mdr_we   = dmem_ack && (op_code == OP_LOAD);
        pc_we    = dmem_ack && (op_code == OP_STORE);
      end
      S_WB: begin
        rf_we = dec_wr_reg;
        pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state, trap cause and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      trap_cause <= CAUSE_NONE;
      instret    <= 32'd0;
    end else begin
      if (pc_we) begin
        instret <= instret + 32'd1;
      end
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
          end else if (tmo_expired) begin
            state_q    <= S_TRAP;
            trap_cause <= CAUSE_IMEM;
          end
        end
        S_DECODE: begin
          if (is_legal(op_code)) begin
            state_q <= S_EXEC;
          end else begin
            state_q    <= S_TRAP;
            trap_cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          if ((op_code == OP_LOAD) || (op_code == OP_STORE)) begin
            state_q <= S_MEM;
          end else if (op_code == OP_BRANCH) begin
            state_q <= boundary_next;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_q <= (op_code == OP_STORE) ? boundary_next : S_WB;
          end else if (tmo_expired) begin
            state_q    <= S_TRAP;
            trap_cause <= CAUSE_DMEM;
          end
        end
        S_WB: state_q <= boundary_next;
        S_HALT: begin
          if (resume && !halt_req) begin
            state_q <= S_FETCH;
          end
        end
        S_TRAP: begin
          if (resume) begin
            state_q    <= S_FETCH;
            trap_cause <= CAUSE_NONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// tb/tb_rv32i_mc_sequencer.sv - directed self-checking bench for rv32i_mc_sequencer
module tb_rv32i_mc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        halt_req;
  logic        resume;
  logic [6:0]  op_code;
  logic        dec_wr_reg;
  logic        dec_mem_wr;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        alu_out_we;
  logic        mdr_we;
  logic        rf_we;
  logic        pc_we;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        halted;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_mc_sequencer #(.MEM_TIMEOUT(16), .TMO_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt_req   (halt_req),
    .resume     (resume),
    .op_code    (op_code),
    .dec_wr_reg (dec_wr_reg),
    .dec_mem_wr (dec_mem_wr),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_we      (ir_we),
    .alu_out_we (alu_out_we),
    .mdr_we     (mdr_we),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .instret    (instret),
    .trap       (trap),
    .trap_cause (trap_cause),
    .halted     (halted),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch with an immediate ack; returns with DUT in DECODE.
  task automatic fetch_now(input logic [6:0] op, input logic wr, input logic mw);
    op_code    = op;
    dec_wr_reg = wr;
    dec_mem_wr = mw;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt_req = 0; resume = 0; op_code = 7'd0;
    dec_wr_reg = 0; dec_mem_wr = 0; imem_ack = 0; dmem_ack = 0;
    tick(); tick();
    n_checks++;
    if (state !== 3'd0 || instret !== 32'd0 || trap_cause !== 2'b00 || trap !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d instret=%0d cause=%b trap=%b halted=%b, want 0/0/00/0/0", state, instret, trap_cause, trap, halted);
    end
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, ir_we, alu_out_we, mdr_we, rf_we, pc_we} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: strobes=%b, want 00000000", {imem_req, dmem_req, dmem_we, ir_we, alu_out_we, mdr_we, rf_we, pc_we});
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: state=%0d imem_req=%b, want 0/0", state, imem_req);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_to_fetch: state=%0d imem_req=%b, want 1/1", state, imem_req);
    end
  endtask

  task automatic test_add();
    op_code = 7'b0110011; dec_wr_reg = 1; dec_mem_wr = 0; imem_ack = 1;
    #1;
    n_checks++;
    if (state !== 3'd1 || imem_req !== 1'b1 || ir_we !== 1'b1 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL add_fetch: state=%0d imem_req=%b ir_we=%b rf_we=%b, want 1/1/1/0", state, imem_req, ir_we, rf_we);
    end
    tick(); imem_ack = 0; #1;
    n_checks++;
    if (state !== 3'd2 || {imem_req, dmem_req, ir_we, alu_out_we, mdr_we, rf_we, pc_we} !== 7'd0) begin
      n_fail++;
      $display("FAIL add_decode: state=%0d strobes=%b, want 2/0000000", state, {imem_req, dmem_req, ir_we, alu_out_we, mdr_we, rf_we, pc_we});
    end
    tick(); #1;
    n_checks++;
    if (state !== 3'd3 || alu_out_we !== 1'b1 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL add_exec: state=%0d alu_out_we=%b pc_we=%b rf_we=%b, want 3/1/0/0", state, alu_out_we, pc_we, rf_we);
    end
    tick(); #1;
    n_checks++;
    if (state !== 3'd5 || rf_we !== 1'b1 || pc_we !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wb: state=%0d rf_we=%b pc_we=%b, want 5/1/1", state, rf_we, pc_we);
    end
    tick(); #1;
    n_checks++;
    if (state !== 3'd1 || instret !== 32'd1) begin
      n_fail++;
      $display("FAIL add_retire: state=%0d instret=%0d, want 1/1", state, instret);
    end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    logic we_seen = 1'b0;
    logic mdr_bad = 1'b0;
    fetch_now(7'b0000011, 1'b1, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (dmem_req) req_cycles++;
      if (dmem_we) we_seen = 1'b1;
      if (mdr_we !== (i == 3)) mdr_bad = 1'b1;
      tick();
    end
    dmem_ack = 0;
    n_checks++;
    if (req_cycles != 4 || we_seen !== 1'b0 || mdr_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL load_mem: req_cycles=%0d we_seen=%b mdr_bad=%b, want 4/0/0", req_cycles, we_seen, mdr_bad);
    end
    #1;
    n_checks++;
    if (state !== 3'd5 || rf_we !== 1'b1 || mdr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wb: state=%0d rf_we=%b mdr_we=%b, want 5/1/0", state, rf_we, mdr_we);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || instret !== 32'd2) begin
      n_fail++;
      $display("FAIL load_retire: state=%0d instret=%0d, want 1/2 after 8 cycles", state, instret);
    end
  endtask

  task automatic test_store();
    logic rf_seen = 1'b0;
    fetch_now(7'b0100011, 1'b0, 1'b1);
    if (rf_we) rf_seen = 1'b1;
    tick();
    if (rf_we) rf_seen = 1'b1;
    tick();
    dmem_ack = 1;
    #1;
    if (rf_we) rf_seen = 1'b1;
    n_checks++;
    if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || pc_we !== 1'b1 || mdr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL store_mem: state=%0d dmem_req=%b dmem_we=%b pc_we=%b mdr_we=%b, want 4/1/1/1/0", state, dmem_req, dmem_we, pc_we, mdr_we);
    end
    tick();
    dmem_ack = 0;
    #1;
    n_checks++;
    if (state !== 3'd1 || instret !== 32'd3 || rf_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL store_retire: state=%0d instret=%0d rf_seen=%b, want 1/3/0", state, instret, rf_seen);
    end
  endtask

  task automatic test_illegal();
    fetch_now(7'b0000000, 1'b0, 1'b0);
    tick(); #1;
    n_checks++;
    if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'b01 || instret !== 32'd3 || pc_we !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_trap: state=%0d trap=%b cause=%b instret=%0d pc_we=%b, want 7/1/01/3/0", state, trap, trap_cause, instret, pc_we);
    end
    tick();
    n_checks++;
    if (state !== 3'd7 || trap_cause !== 2'b01) begin
      n_fail++;
      $display("FAIL illegal_hold: state=%0d cause=%b, want 7/01", state, trap_cause);
    end
    resume = 1;
    tick();
    resume = 0;
    #1;
    n_checks++;
    if (state !== 3'd1 || trap_cause !== 2'b00 || trap !== 1'b0 || instret !== 32'd3) begin
      n_fail++;
      $display("FAIL illegal_resume: state=%0d cause=%b trap=%b instret=%0d, want 1/00/0/3", state, trap_cause, trap, instret);
    end
  endtask

  task automatic test_imem_timeout();
    int n = 0;
    imem_ack = 0;
    while (state == 3'd1 && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 16 || state !== 3'd7 || trap_cause !== 2'b10) begin
      n_fail++;
      $display("FAIL imem_timeout: fetch_cycles=%0d state=%0d cause=%b, want 16/7/10", n, state, trap_cause);
    end
    resume = 1; tick(); resume = 0;
    op_code = 7'b0110011; dec_wr_reg = 1; dec_mem_wr = 0;
    for (int i = 1; i < 16; i++) tick();
    n_checks++;
    if (state !== 3'd1 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL imem_cycle16_state: state=%0d imem_req=%b, want 1/1", state, imem_req);
    end
    imem_ack = 1;
    tick();
    imem_ack = 0;
    #1;
    n_checks++;
    if (state !== 3'd2 || trap !== 1'b0 || trap_cause !== 2'b00) begin
      n_fail++;
      $display("FAIL imem_ack_last: state=%0d trap=%b cause=%b, want 2/0/00", state, trap, trap_cause);
    end
    tick(); tick(); tick();
    n_checks++;
    if (state !== 3'd1 || instret !== 32'd4) begin
      n_fail++;
      $display("FAIL imem_late_retire: state=%0d instret=%0d, want 1/4", state, instret);
    end
  endtask

  task automatic test_dmem_timeout();
    int n = 0;
    fetch_now(7'b0000011, 1'b1, 1'b0);
    tick();
    tick();
    while (state == 3'd4 && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 16 || state !== 3'd7 || trap_cause !== 2'b11 || instret !== 32'd4) begin
      n_fail++;
      $display("FAIL dmem_timeout: mem_cycles=%0d state=%0d cause=%b instret=%0d, want 16/7/11/4", n, state, trap_cause, instret);
    end
    resume = 1; tick(); resume = 0;
  endtask

  task automatic test_halt_branch();
    fetch_now(7'b1100011, 1'b0, 1'b0);
    tick();
    halt_req = 1;
    #1;
    n_checks++;
    if (state !== 3'd3 || pc_we !== 1'b1 || alu_out_we !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_exec: state=%0d pc_we=%b alu_out_we=%b, want 3/1/1", state, pc_we, alu_out_we);
    end
    tick();
    n_checks++;
    if (state !== 3'd6 || halted !== 1'b1 || imem_req !== 1'b0 || instret !== 32'd5) begin
      n_fail++;
      $display("FAIL beq_halt: state=%0d halted=%b imem_req=%b instret=%0d, want 6/1/0/5", state, halted, imem_req, instret);
    end
    resume = 1;
    tick();
    n_checks++;
    if (state !== 3'd6) begin
      n_fail++;
      $display("FAIL halt_held: state=%0d, want 6 while halt_req=1", state);
    end
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    halt_req = 0;
    tick();
    resume = 0;
    #1;
    n_checks++;
    if (state !== 3'd1 || halted !== 1'b0 || instret !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL halt_resume: state=%0d halted=%b instret=%h, want 1/0/ffffffff", state, halted, instret);
    end
    fetch_now(7'b1100011, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (state !== 3'd1 || instret !== 32'd0) begin
      n_fail++;
      $display("FAIL instret_wrap: state=%0d instret=%h, want 1/00000000", state, instret);
    end
  endtask

  task automatic test_async_reset();
    fetch_now(7'b0000011, 1'b1, 1'b0);
    tick();
    tick();
    #1;
    n_checks++;
    if (state !== 3'd4 || dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: state=%0d dmem_req=%b, want 4/1", state, dmem_req);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (state !== 3'd0 || dmem_req !== 1'b0 || alu_out_we !== 1'b0 || instret !== 32'd0) begin
      n_fail++;
      $display("FAIL arst_drop: state=%0d dmem_req=%b alu_out_we=%b instret=%0d, want 0/0/0/0", state, dmem_req, alu_out_we, instret);
    end
    tick();
    rst_n = 1;
    #1;
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_idle: state=%0d, want 0", state);
    end
    tick();
    n_checks++;
    if (state !== 3'd1 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_restart: state=%0d imem_req=%b, want 1/1", state, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    test_halt_branch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
